// File: rtl/sr_flag_pkg.sv
// Opcodes and toggle-decode helper shared by the set/reset flag bank.
package sr_flag_pkg;

    typedef enum logic [1:0] {
        OP_NOP = 2'b00,
        OP_SET = 2'b01,
        OP_CLR = 2'b10,
        OP_TOG = 2'b11
    } op_e;

    // Toggle enable that takes flag state q to the state the opcode asks for.
    function automatic logic flag_toggle(input op_e op, input logic q);
        logic t;
        case (op)
            OP_SET:  t = ~q;
            OP_CLR:  t = q;
            OP_TOG:  t = 1'b1;
            default: t = 1'b0;
        endcase
        return t;
    endfunction

endpackage

// File: rtl/tff_cell.sv
// Single flag bit: T flop with async active-low reset and a sync clear.
module tff_cell (
    input  logic clk,
    input  logic reset_n,
    input  logic i_clr,
    input  logic i_t,
    output logic o_q
);

    logic r_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_q <= 1'b0;
        end else if (i_clr) begin
            r_q <= 1'b0;
        end else if (i_t) begin
            r_q <= ~r_q;
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/sr_flag_arbiter.sv
// Round-robin arbitrated set/clear/toggle access to a bank of flag bits.
module sr_flag_arbiter
    import sr_flag_pkg::*;
#(
    parameter  int NREQ   = 4,
    parameter  int NFLAGS = 8,
    localparam int IDXW   = $clog2(NFLAGS),
    localparam int PW     = $clog2(NREQ)
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [2*NREQ-1:0]    req_op,
    input  logic [IDXW*NREQ-1:0] req_idx,
    output logic [NREQ-1:0]      req_ready,
    input  logic                 clear_all,
    output logic [NFLAGS-1:0]    flags,
    output logic                 apply_valid,
    output logic [PW-1:0]        apply_id
);

    logic [PW-1:0]     r_ptr;
    logic              r_sv;
    op_e               r_op;
    logic [IDXW-1:0]   r_idx;
    logic [PW-1:0]     r_id;

    logic [NREQ-1:0]   w_grant;
    logic              w_found;
    logic [PW-1:0]     w_gid;
    op_e               w_op;
    logic [IDXW-1:0]   w_idx;
    logic [NFLAGS-1:0] w_t;
    logic [NFLAGS-1:0] w_q;

    // Scan from the pointer; first valid requester wins.
    always_comb begin
        int j;
        j       = 0;
        w_grant = '0;
        w_found = 1'b0;
        w_gid   = '0;
        w_op    = OP_NOP;
        w_idx   = '0;
        if (reset_n && !clear_all) begin
            for (int k = 0; k < NREQ; k++) begin
                j = int'(r_ptr) + k;
                if (j >= NREQ) j = j - NREQ;
                if (!w_found && req_valid[j]) begin
                    w_found    = 1'b1;
                    w_grant[j] = 1'b1;
                    w_gid      = PW'(j);
                    w_op       = op_e'(req_op[2*j +: 2]);
                    w_idx      = req_idx[IDXW*j +: IDXW];
                end
            end
        end
    end

    assign req_ready = w_grant;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_ptr <= '0;
            r_sv  <= 1'b0;
            r_op  <= OP_NOP;
            r_idx <= '0;
            r_id  <= '0;
        end else begin
            r_sv <= w_found;
            if (w_found) begin
                r_op  <= w_op;
                r_idx <= w_idx;
                r_id  <= w_gid;
                if (w_gid == PW'(NREQ - 1)) begin
                    r_ptr <= '0;
                end else begin
                    r_ptr <= w_gid + PW'(1);
                end
            end
        end
    end

    // Out-of-range indices match no cell, so they apply as a no-op.
    for (genvar f = 0; f < NFLAGS; f++) begin : g_flag
        assign w_t[f] = r_sv && (r_idx == IDXW'(f)) &&
                        flag_toggle(r_op, w_q[f]);

        tff_cell u_cell (
            .clk     (clk),
            .reset_n (reset_n),
            .i_clr   (clear_all),
            .i_t     (w_t[f]),
            .o_q     (w_q[f])
        );
    end

    assign flags       = w_q;
    assign apply_valid = r_sv & ~clear_all;
    assign apply_id    = r_id;

endmodule
